// File: rtl/irs_pkg.sv
// Shared helpers for the credit sink: counter width derivation and DEPTH legality.
package irs_pkg;

    localparam int IRS_DEPTH_MIN = 1;
    localparam int IRS_DEPTH_MAX = 64;

    // Occupancy and credit counters must hold the value DEPTH itself.
    function automatic int irs_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit irs_depth_legal(input int depth);
        return (depth >= IRS_DEPTH_MIN) && (depth <= IRS_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/irs_crd_fifo.sv
// Synchronous FIFO, DEPTH entries (any DEPTH), unregistered head read; 1-cycle push-to-visible.
// No internal protection: the caller must never push when full without a pop, nor pop when empty.
module irs_crd_fifo
    import irs_pkg::*;
#(
    parameter int PYLD_W = 1,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [PYLD_W-1:0] i_push_dat,
    input  logic              i_pop,
    output logic [PYLD_W-1:0] o_head_dat,
    output logic [CNT_W-1:0]  o_level,
    output logic              o_vld
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PYLD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_level;
    logic [PTR_W-1:0]  w_wptr_nxt;
    logic [PTR_W-1:0]  w_rptr_nxt;

    // Wrap by comparison so non-power-of-two depths never touch unused slots.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_wptr_nxt = ptr_inc(r_wptr);
    assign w_rptr_nxt = ptr_inc(r_rptr);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (i_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + CNT_W'(1);
                2'b01:   r_level <= r_level - CNT_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rptr];
    assign o_level    = r_level;
    assign o_vld      = (r_level != '0);

endmodule

// File: rtl/irs_credit_sink.sv
// Credit-return terminator for a no-ready pipeline: buffers every beat, returns one credit per freed slot.
// Push visible 1 cycle later; credits registered, one per cycle; a beat arriving with no free slot is dropped and sets ovf_o.
module irs_credit_sink
    import irs_pkg::*;
#(
    parameter int  PYLD_W = 1,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = irs_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [PYLD_W-1:0] payload_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PYLD_W-1:0] payload_o,
    output logic              credit_o,
    output logic [CNT_W-1:0]  level_o,
    output logic              ovf_o
);

    if (!irs_depth_legal(DEPTH)) begin : g_depth_chk
        $fatal(1, "irs_credit_sink: DEPTH must lie in 1..64");
    end

    logic              w_vld;
    logic              w_full;
    logic              w_pop;
    logic              w_push_acc;
    logic              w_drop;
    logic [CNT_W-1:0]  w_level;
    logic [CNT_W-1:0]  w_owed_eff;
    logic [PYLD_W-1:0] w_head_dat;

    logic [CNT_W-1:0]  r_owed;
    logic              r_credit;
    logic              r_ovf;

    assign w_full     = (w_level == CNT_W'(DEPTH));
    assign w_pop      = w_vld && ready_i;
    // A pop in the same cycle frees the slot the incoming beat needs.
    assign w_push_acc = valid_i && (!w_full || w_pop);
    assign w_drop     = valid_i && w_full && !w_pop;
    assign w_owed_eff = r_owed + CNT_W'(w_pop);

    irs_crd_fifo #(
        .PYLD_W (PYLD_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push_acc),
        .i_push_dat (payload_i),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_level    (w_level),
        .o_vld      (w_vld)
    );

    // Reset loads the full pool as owed, which produces the initial grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owed   <= CNT_W'(DEPTH);
            r_credit <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_owed_eff != '0) begin
                r_credit <= 1'b1;
                r_owed   <= w_owed_eff - CNT_W'(1);
            end else begin
                r_credit <= 1'b0;
                r_owed   <= w_owed_eff;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (({1'b0, r_owed} + {1'b0, w_level}) <= (CNT_W + 1)'(DEPTH));
        end
    end

    assign valid_o   = w_vld;
    assign payload_o = w_head_dat;
    assign credit_o  = r_credit;
    assign level_o   = w_level;
    assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_irs_credit_sink.sv
// Directed bench: DEPTH=4 instance for the credit/overflow scenarios, DEPTH=3 instance for wrap and mid-stream reset.
module tb_irs_credit_sink;

    logic clk;
    int   n_cmp = 0;
    int   n_mis = 0;

    logic       a_rst, a_vld_i, a_rdy_i, a_vld_o, a_crd_o, a_ovf_o;
    logic [3:0] a_dat_i, a_dat_o;
    logic [2:0] a_lvl_o;

    logic       b_rst, b_vld_i, b_rdy_i, b_vld_o, b_crd_o, b_ovf_o;
    logic [7:0] b_dat_i, b_dat_o;
    logic [1:0] b_lvl_o;

    logic [7:0] exp_q[$];
    int         b_cred;
    int         b_pops;
    int         crd_cnt;

    irs_credit_sink #(.PYLD_W(4), .DEPTH(4)) u_a (
        .clk(clk), .rst(a_rst), .valid_i(a_vld_i), .payload_i(a_dat_i),
        .valid_o(a_vld_o), .ready_i(a_rdy_i), .payload_o(a_dat_o),
        .credit_o(a_crd_o), .level_o(a_lvl_o), .ovf_o(a_ovf_o)
    );

    irs_credit_sink #(.PYLD_W(8), .DEPTH(3)) u_b (
        .clk(clk), .rst(b_rst), .valid_i(b_vld_i), .payload_i(b_dat_i),
        .valid_o(b_vld_o), .ready_i(b_rdy_i), .payload_o(b_dat_o),
        .credit_o(b_crd_o), .level_o(b_lvl_o), .ovf_o(b_ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release A from reset and expect exactly four back-to-back credits.
    task automatic a_release();
        a_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("a_init_crd", 32'(a_crd_o), (i < 4) ? 1 : 0);
        end
        chk("a_init_lvl", 32'(a_lvl_o), 0);
        chk("a_init_vld", 32'(a_vld_o), 0);
    endtask

    task automatic a_push(input logic [3:0] v);
        a_vld_i = 1'b1;
        a_dat_i = v;
        tick();
        a_vld_i = 1'b0;
    endtask

    task automatic a_reset_edge();
        a_rst   = 1'b1;
        a_vld_i = 1'b0;
        a_rdy_i = 1'b0;
        tick();
        chk("a_rst_lvl", 32'(a_lvl_o), 0);
        chk("a_rst_vld", 32'(a_vld_o), 0);
        chk("a_rst_crd", 32'(a_crd_o), 0);
        chk("a_rst_ovf", 32'(a_ovf_o), 0);
    endtask

    task automatic b_release();
        b_rst  = 1'b0;
        b_cred = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_init_crd", 32'(b_crd_o), (i < 3) ? 1 : 0);
            if (b_crd_o) b_cred++;
        end
    endtask

    // Credit-respecting random sender with a random-ready consumer, drained at the end.
    task automatic b_traffic(input int nbeats);
        int sent = 0;
        int cyc  = 0;
        b_pops = 0;
        while ((sent < nbeats || exp_q.size() != 0) && cyc < 500) begin
            b_rdy_i = ($urandom_range(0, 2) != 0);
            if (b_vld_o && b_rdy_i) begin
                chk("b_order", 32'(b_dat_o), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                b_pops++;
            end
            b_vld_i = 1'b0;
            if (sent < nbeats && b_cred > 0 && $urandom_range(0, 3) != 0) begin
                b_vld_i = 1'b1;
                b_dat_i = 8'($urandom);
                exp_q.push_back(b_dat_i);
                b_cred--;
                sent++;
            end
            tick();
            cyc++;
            if (b_crd_o) b_cred++;
        end
        b_vld_i = 1'b0;
        b_rdy_i = 1'b0;
        chk("b_no_timeout", 32'(cyc < 500), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b_crd_o) b_cred++;
        end
        chk("b_pops", b_pops, nbeats);
        chk("b_cred_back", b_cred, 3);
        chk("b_lvl_empty", 32'(b_lvl_o), 0);
        chk("b_ovf_clear", 32'(b_ovf_o), 0);
    endtask

    initial begin
        a_rst = 1'b1; a_vld_i = 1'b0; a_rdy_i = 1'b0; a_dat_i = '0;
        b_rst = 1'b1; b_vld_i = 1'b0; b_rdy_i = 1'b0; b_dat_i = '0;
        tick();
        tick();
        chk("a_rst_vld", 32'(a_vld_o), 0);
        chk("a_rst_crd", 32'(a_crd_o), 0);
        chk("a_rst_lvl", 32'(a_lvl_o), 0);
        chk("a_rst_ovf", 32'(a_ovf_o), 0);
        a_release();

        // Fill with ready low: head holds, no extra credits.
        for (int i = 0; i < 4; i++) begin
            a_push(4'(4'hA + i));
            chk("a_fill_crd", 32'(a_crd_o), 0);
        end
        chk("a_full_lvl", 32'(a_lvl_o), 4);
        chk("a_full_vld", 32'(a_vld_o), 1);
        chk("a_full_head", 32'(a_dat_o), 'hA);
        tick();
        tick();
        chk("a_hold_head", 32'(a_dat_o), 'hA);
        chk("a_hold_crd", 32'(a_crd_o), 0);

        // Single pop from full.
        a_rdy_i = 1'b1;
        tick();
        a_rdy_i = 1'b0;
        chk("a_pop1_lvl", 32'(a_lvl_o), 3);
        chk("a_pop1_head", 32'(a_dat_o), 'hB);
        chk("a_pop1_crd", 32'(a_crd_o), 1);
        tick();
        chk("a_pop1_crd_end", 32'(a_crd_o), 0);
        chk("a_pop1_lvl2", 32'(a_lvl_o), 3);

        // Mid-operation reset, then overflow at full.
        a_reset_edge();
        a_release();
        for (int i = 0; i < 4; i++) a_push(4'(4'hA + i));
        a_push(4'hE);
        chk("a_ovf_set", 32'(a_ovf_o), 1);
        chk("a_ovf_lvl", 32'(a_lvl_o), 4);
        tick();
        tick();
        chk("a_ovf_sticky", 32'(a_ovf_o), 1);
        a_rdy_i = 1'b1;
        crd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            chk("a_ovf_order", 32'(a_dat_o), 32'('hA + i));
            tick();
            if (a_crd_o) crd_cnt++;
        end
        a_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_crd_o) crd_cnt++;
        end
        chk("a_ovf_drain_vld", 32'(a_vld_o), 0);
        chk("a_ovf_drain_lvl", 32'(a_lvl_o), 0);
        chk("a_ovf_still", 32'(a_ovf_o), 1);
        chk("a_ovf_credits", crd_cnt, 4);

        // Push and pop together at full: accepted, no overflow.
        a_reset_edge();
        a_release();
        for (int i = 0; i < 4; i++) a_push(4'(4'hA + i));
        a_vld_i = 1'b1;
        a_dat_i = 4'hE;
        a_rdy_i = 1'b1;
        crd_cnt = 0;
        chk("a_pp_head", 32'(a_dat_o), 'hA);
        tick();
        if (a_crd_o) crd_cnt++;
        a_vld_i = 1'b0;
        chk("a_pp_lvl", 32'(a_lvl_o), 4);
        chk("a_pp_ovf", 32'(a_ovf_o), 0);
        for (int i = 0; i < 4; i++) begin
            chk("a_pp_order", 32'(a_dat_o), 32'('hB + i));
            tick();
            if (a_crd_o) crd_cnt++;
        end
        a_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_crd_o) crd_cnt++;
        end
        chk("a_pp_credits", crd_cnt, 5);
        chk("a_pp_lvl_end", 32'(a_lvl_o), 0);

        // DEPTH=3: wrap-around traffic, reset with beats stranded, more traffic.
        b_release();
        b_traffic(10);
        for (int i = 0; i < 2; i++) begin
            b_vld_i = 1'b1;
            b_dat_i = 8'(8'h50 + i);
            b_cred--;
            tick();
        end
        b_vld_i = 1'b0;
        chk("b_strand_lvl", 32'(b_lvl_o), 2);
        b_rst = 1'b1;
        tick();
        chk("b_rst_lvl", 32'(b_lvl_o), 0);
        chk("b_rst_vld", 32'(b_vld_o), 0);
        chk("b_rst_crd", 32'(b_crd_o), 0);
        chk("b_rst_ovf", 32'(b_ovf_o), 0);
        exp_q.delete();
        b_release();
        chk("b_rst_cred_total", b_cred, 3);
        b_traffic(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irs_credit_sink.md
# irs_credit_sink

- Receive-side terminator for a credit-based valid/payload channel, for links built from register slices with no ready (`TYPE_NO_READY`).
- The far-end sender holds a credit counter and never sees backpressure. This block absorbs every arriving beat into a local DEPTH-entry buffer and presents it downstream on a standard valid/ready interface.
- It returns one credit pulse upstream for every buffer slot freed, including the initial DEPTH credits after reset.
- Sits at the destination port of any long no-ready pipeline in the mesh.

## Interface
Parameters:
- `PYLD_W`, 1: payload width in bits.
- `DEPTH`, 4: buffer entries. Also the total credit pool. Legal range 1..64.
- `CNT_W`, $clog2(DEPTH+1): width of occupancy and credit counters. Derived, not overridden.

Ports:
- `clk`  in  1  the single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  beat arriving from the no-ready pipeline. No ready is returned.
- `payload_i`  in  PYLD_W  data accompanying `valid_i`.
- `valid_o`  out  1  buffer non-empty; head entry presented.
- `ready_i`  in  1  downstream accepts the head when high with `valid_o`.
- `payload_o`  out  PYLD_W  head entry.
- `credit_o`  out  1  one-cycle pulse; each high cycle returns exactly one credit to the sender.
- `level_o`  out  CNT_W  current buffer occupancy.
- `ovf_o`  out  1  sticky error: a beat arrived with no free slot.

## Operation
- Push: `valid_i` high → write `payload_i` at the write pointer.
  - The push is accepted when `level < DEPTH`, or when the buffer is full and a pop occurs in the same cycle.
  - Otherwise the beat is dropped, `ovf_o` is set, and buffer contents are untouched.
- Pop: `valid_o && ready_i` → read pointer advances.
  - `valid_o` is `level != 0`.
  - `payload_o` is the storage at the read pointer; it is stable while `valid_o && !ready_i`.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two; wrap by compare-to-(DEPTH-1), not bit truncation.
- `level` next value = level + push_acc − pop. Simultaneous push and pop leaves level unchanged.
- Credit owed counter `owed` (CNT_W bits):
  - Reset value is DEPTH; this is the initial credit grant.
  - Each cycle, `owed_eff = owed + pop`.
  - If `owed_eff != 0`: `credit_o` is registered high for the next cycle and `owed <= owed_eff − 1`.
  - Otherwise `credit_o` is registered low and `owed <= owed_eff`.
- Result: after reset, DEPTH back-to-back credit pulses are issued; each later pop yields exactly one pulse, serialized at one per cycle.
- Invariant checked by assertion: `owed + level <= DEPTH`.
- `ovf_o` is cleared only by `rst`.

## Timing
- Reset values:
  - `valid_o`=0, `credit_o`=0, `level_o`=0, `ovf_o`=0.
  - `owed`=DEPTH, both pointers 0.
  - `payload_o` is don't-care while `valid_o`=0.
- Reset applied mid-operation:
  - Buffered data is discarded, `owed` returns to DEPTH, and `ovf_o` clears at that edge.
  - The sender is required to reset together with this block.
- Initial credits: first `credit_o` pulse in the cycle after the first edge sampled with `rst`=0. Pulses continue for DEPTH consecutive cycles.
- Push to `valid_o` latency is 1 cycle: a beat sampled at edge t is visible after edge t. There is no combinational `valid_i`→`valid_o` path.
- Pop to credit latency is 1 cycle when `owed` was 0. Otherwise the credit queues behind outstanding credits, at one per cycle.
- `level_o` and `ovf_o` update at the same edge as the push or pop that changes them.
- `ready_i`→`credit_o` path is registered. `ready_i` has no combinational path to `valid_o` or `payload_o`.

## Structure
- Package `irs_pkg` holds:
  - the CNT_W derivation function;
  - the DEPTH legality check, elaborated as a fatal error outside 1..64.
- Storage and pointers go in one sub-module, `irs_crd_fifo`: synchronous FIFO with push/pop/level and an unregistered head read.
- The top module contains the accept/overflow logic, the `owed` counter, the `credit_o` register and `ovf_o`.

## Test plan
- Reset release, DEPTH=4, no traffic → `credit_o` high exactly in cycles 1–4, then low. `level_o`=0, `valid_o`=0.
- Push 0xA,0xB,0xC,0xD with `ready_i`=0 → `level_o`=4, `valid_o`=1, `payload_o`=0xA held, no `credit_o` after the initial four.
- From full, raise `ready_i` for one cycle → 0xA popped, `level_o`=3, `payload_o`=0xB, single `credit_o` pulse the next cycle.
- At full, push 0xE with `ready_i`=0 → `ovf_o`=1 and stays set, `level_o`=4, later pops yield 0xA..0xD only.
- At full, push 0xE and pop in the same cycle → no overflow, `level_o`=4, output order 0xB,0xC,0xD,0xE. One credit is issued per pop.
- DEPTH=3 (non-power-of-two), 20 random beats with random `ready_i`, `rst` pulsed mid-stream:
  - Order is preserved and credits equal pops across the wrap.
  - After the reset, exactly 3 initial credits are issued and `ovf_o`=0.
